// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared widths, queue entry type and helpers for the writeback arbiter
package regfile_wb_pkg;

    localparam int WB_BIT_COUNT      = 32;
    localparam int WB_REGISTER_COUNT = 32;
    localparam int WB_QUEUE_DEPTH    = 2;
    localparam int WB_AW             = $clog2(WB_REGISTER_COUNT);

    localparam logic [WB_AW-1:0] WB_ADDR_ZERO = '0;

    typedef struct packed {
        logic                    live;
        logic [WB_AW-1:0]        addr;
        logic [WB_BIT_COUNT-1:0] data;
    } wb_entry_t;

    function automatic logic [WB_REGISTER_COUNT-1:0] wb_onehot(input logic [WB_AW-1:0] addr);
        logic [WB_REGISTER_COUNT-1:0] one;
        one = {{(WB_REGISTER_COUNT-1){1'b0}}, 1'b1};
        return one << addr;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - circular buffer of long-latency results with squash-by-address and live mask
module wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = WB_QUEUE_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    input  logic                         squash_valid,
    input  logic [WB_AW-1:0]             squash_addr,
    output wb_entry_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [WB_REGISTER_COUNT-1:0] live_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    wb_entry_t   entries [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = entries[rd_ptr[PW-1:0]];

    // Popped slots are marked dead so unoccupied entries never contribute to the mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_valid && entries[i].addr == squash_addr) begin
                    entries[i].live <= 1'b0;
                end
            end
            if (pop && !empty) begin
                entries[rd_ptr[PW-1:0]].live <= 1'b0;
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !full) begin
                entries[wr_ptr[PW-1:0]] <= push_entry;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].live) begin
                live_mask = live_mask | wb_onehot(entries[i].addr);
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write-port arbiter; REGFILE_WB_BYPASS_EN enables same-cycle result bypass
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int BIT_COUNT      = WB_BIT_COUNT,
    parameter int REGISTER_COUNT = WB_REGISTER_COUNT,
    parameter int QUEUE_DEPTH    = WB_QUEUE_DEPTH,
    localparam int AW            = $clog2(REGISTER_COUNT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      PipeValid,
    input  logic [AW-1:0]             PipeRdAdr,
    input  logic [BIT_COUNT-1:0]      PipeRd,
    input  logic                      MultiValid,
    input  logic [AW-1:0]             MultiRdAdr,
    input  logic [BIT_COUNT-1:0]      MultiRd,
    output logic                      MultiReady,
    output logic                      WriteEnable,
    output logic [AW-1:0]             rd1Adr,
    output logic [BIT_COUNT-1:0]      Rd1,
    output logic [REGISTER_COUNT-1:0] PendingMask
);

    wb_entry_t head;
    wb_entry_t push_entry;
    logic      q_full;
    logic      q_empty;
    logic      pop;
    logic      push;
    logic      bypass;
    logic      collide;

    always_comb begin
        WriteEnable = 1'b0;
        rd1Adr      = '0;
        Rd1         = '0;
        pop         = 1'b0;
        bypass      = 1'b0;
        if (reset) begin
            WriteEnable = 1'b0;
        end else if (PipeValid) begin
            WriteEnable = (PipeRdAdr != WB_ADDR_ZERO);
            rd1Adr      = PipeRdAdr;
            Rd1         = PipeRd;
        end else if (!q_empty) begin
            // Dead and x0 heads are popped here too, just without the strobe.
            pop         = 1'b1;
            WriteEnable = head.live && (head.addr != WB_ADDR_ZERO);
            rd1Adr      = head.addr;
            Rd1         = head.data;
        end
`ifdef REGFILE_WB_BYPASS_EN
        else if (MultiValid) begin
            bypass      = 1'b1;
            WriteEnable = (MultiRdAdr != WB_ADDR_ZERO);
            rd1Adr      = MultiRdAdr;
            Rd1         = MultiRd;
        end
`endif
    end

    assign MultiReady = !q_full;
    // A result colliding with a same-cycle pipeline write is older and simply discarded.
    assign collide    = PipeValid && (MultiRdAdr == PipeRdAdr);
    assign push       = MultiValid && MultiReady && !collide && !bypass;
    assign push_entry = '{live: (MultiRdAdr != WB_ADDR_ZERO), addr: MultiRdAdr, data: MultiRd};

    wb_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_entry   (push_entry),
        .pop          (pop),
        .squash_valid (PipeValid),
        .squash_addr  (PipeRdAdr),
        .head         (head),
        .full         (q_full),
        .empty        (q_empty),
        .live_mask    (PendingMask)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - scoreboard bench for regfile_writeback against a queue-level reference model
module tb_regfile_writeback;

    localparam int BW    = 32;
    localparam int RC    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          PipeValid = 1'b0;
    logic [AW-1:0] PipeRdAdr = '0;
    logic [BW-1:0] PipeRd = '0;
    logic          MultiValid = 1'b0;
    logic [AW-1:0] MultiRdAdr = '0;
    logic [BW-1:0] MultiRd = '0;
    logic          MultiReady;
    logic          WriteEnable;
    logic [AW-1:0] rd1Adr;
    logic [BW-1:0] Rd1;
    logic [RC-1:0] PendingMask;

    regfile_writeback dut (
        .clk         (clk),
        .reset       (reset),
        .PipeValid   (PipeValid),
        .PipeRdAdr   (PipeRdAdr),
        .PipeRd      (PipeRd),
        .MultiValid  (MultiValid),
        .MultiRdAdr  (MultiRdAdr),
        .MultiRd     (MultiRd),
        .MultiReady  (MultiReady),
        .WriteEnable (WriteEnable),
        .rd1Adr      (rd1Adr),
        .Rd1         (Rd1),
        .PendingMask (PendingMask)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            live;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } pend_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } wr_t;

    pend_t         mq[$];
    wr_t           sb[$];
    int            cyc = 0;
    bit            started = 1'b0;
    bit            exp_ready;
    logic [RC-1:0] exp_mask;
    int            checks = 0;
    int            failures = 0;

    task automatic step(input bit rst, input bit pv, input logic [AW-1:0] pa, input logic [BW-1:0] pd,
                        input bit mv, input logic [AW-1:0] ma, input logic [BW-1:0] md);
        pend_t h;
        bit    bypassed;
        reset      = rst;
        PipeValid  = pv;
        PipeRdAdr  = pa;
        PipeRd     = pd;
        MultiValid = mv;
        MultiRdAdr = ma;
        MultiRd    = md;
        cyc++;
        if (rst) mq.delete();
        exp_ready = (mq.size() < DEPTH);
        exp_mask  = '0;
        foreach (mq[i]) if (mq[i].live && mq[i].addr != 0) exp_mask[mq[i].addr] = 1'b1;
        if (!rst) begin
            bypassed = 1'b0;
            if (pv) begin
                if (pa != 0) sb.push_back('{cyc, pa, pd});
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.live && h.addr != 0) sb.push_back('{cyc, h.addr, h.data});
            end else if (BYP && mv) begin
                bypassed = 1'b1;
                if (ma != 0) sb.push_back('{cyc, ma, md});
            end
            if (pv) foreach (mq[i]) if (mq[i].addr == pa) mq[i].live = 1'b0;
            if (mv && exp_ready && !bypassed && !(pv && ma == pa)) mq.push_back('{1'b1, ma, md});
        end
        started = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (MultiReady !== exp_ready) begin
                failures++;
                $display("FAIL ready cyc=%0d: got %0b need %0b", cyc, MultiReady, exp_ready);
            end
            checks++;
            if (PendingMask !== exp_mask) begin
                failures++;
                $display("FAIL pending_mask cyc=%0d: got %h need %h", cyc, PendingMask, exp_mask);
            end
            checks++;
            if (WriteEnable === 1'b1) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    failures++;
                    $display("FAIL unexpected_write cyc=%0d: got adr=%0d data=%h, need no write", cyc, rd1Adr, Rd1);
                end else begin
                    if (rd1Adr !== sb[0].addr || Rd1 !== sb[0].data) begin
                        failures++;
                        $display("FAIL write_data cyc=%0d: got adr=%0d data=%h need adr=%0d data=%h",
                                 cyc, rd1Adr, Rd1, sb[0].addr, sb[0].data);
                    end
                    void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                failures++;
                $display("FAIL missed_write cyc=%0d: got we=%b need adr=%0d data=%h", cyc, WriteEnable, sb[0].addr, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 5'd3, 32'h1, 1'b0, '0, '0);
        idle(1);
        // reset drain
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 32'hAA);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(3);
        // priority and queueing
        step(1'b0, 1'b1, 5'd7, 32'h22, 1'b1, 5'd3, 32'h11);
        step(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, '0, '0);
        idle(2);
        // full queue
        step(1'b0, 1'b1, 5'd10, 32'h1, 1'b1, 5'd1, 32'hB1);
        step(1'b0, 1'b1, 5'd11, 32'h2, 1'b1, 5'd2, 32'hB2);
        step(1'b0, 1'b1, 5'd12, 32'h3, 1'b1, 5'd4, 32'hB4);
        idle(3);
        // squash
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h33);
        step(1'b0, 1'b1, 5'd9, 32'h44, 1'b0, '0, '0);
        idle(2);
        // x0 and same-cycle collision
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h99);
        idle(2);
        step(1'b0, 1'b1, 5'd4, 32'h66, 1'b1, 5'd4, 32'h55);
        idle(2);
        // bypass / minimum latency
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd6, 32'h77);
        idle(2);
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), 32'($urandom),
                 ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), 32'($urandom));
        end
        idle(6);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d outstanding writes need 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
